ldst_dataio_bridge: RTL and testbench

Bridges the load/store unit's data port to the word-oriented memory/MMU bus, directly downstream of the load/store execution unit. Accepts one byte/halfword/word request at a time. Converts each request into a word-aligned bus transaction with byte-lane mask and lane-shifted write data, and returns the raw read word. Stores are posted: they are complete toward the load/store unit at acceptance. The bridge tracks a single outstanding transaction and absorbs pipeline flushes, including discarding a late read response.

---
 rtl/ldst_bridge_pkg.sv | 62 ++++++
 rtl/dataio_lane_encoder.sv | 23 ++
 rtl/ldst_dataio_bridge.sv | 154 +++++++++++++++
 tb/tb_ldst_dataio_bridge.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldst_bridge_pkg.sv
// Shared definitions for the load/store data-port bridge: widths, access orders,
// FSM states, bus payload and the byte-lane legality/mask function.
package ldst_bridge_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned TID_W    = 14;
    localparam int unsigned MMUMOD_W = 2;
    localparam int unsigned MASK_W   = 4;
    localparam int unsigned ORDER_W  = 2;
    localparam int unsigned OFF_W    = 2;

    typedef enum logic [ORDER_W-1:0] {
        ORDER_BYTE = 2'd0,
        ORDER_HALF = 2'd1,
        ORDER_WORD = 2'd2,
        ORDER_NONE = 2'd3
    } order_t;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_ISSUE   = 2'd1,
        STATE_WAIT_RD = 2'd2,
        STATE_DRAIN   = 2'd3
    } bridgeState_t;

    typedef struct packed {
        logic              illegal;
        logic [MASK_W-1:0] mask;
    } laneSel_t;

    typedef struct packed {
        logic                rw;
        logic [TID_W-1:0]    tid;
        logic [MMUMOD_W-1:0] mmuMod;
        logic [ADDR_W-1:0]   pdt;
        logic [ADDR_W-1:0]   addr;
        logic [MASK_W-1:0]   mask;
        logic [DATA_W-1:0]   data;
    } memPayload_t;

    // Byte enables for an access; illegal accesses get an empty mask.
    function automatic laneSel_t laneSelect(input order_t order, input logic [OFF_W-1:0] off);
        laneSel_t sel;
        sel.illegal = 1'b0;
        sel.mask    = '0;
        case (order)
            ORDER_BYTE: sel.mask = 4'b0001 << off;
            ORDER_HALF: begin
                if (off == 2'd3) sel.illegal = 1'b1;
                else             sel.mask    = 4'b0011 << off;
            end
            ORDER_WORD: begin
                if (off != 2'd0) sel.illegal = 1'b1;
                else             sel.mask    = 4'b1111;
            end
            default:    sel.illegal = 1'b1;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dataio_lane_encoder.sv
// Combinational lane encoder: byte mask, lane-shifted store data and the
// illegal-access flag for one data-port request.
module dataio_lane_encoder
    import ldst_bridge_pkg::*;
(
    input  order_t             order,
    input  logic [OFF_W-1:0]   off,
    input  logic [DATA_W-1:0]  data,
    output logic [MASK_W-1:0]  laneMask_c,
    output logic [DATA_W-1:0]  laneData_c,
    output logic               illegal_c
);

    laneSel_t sel;

    always_comb begin
        sel        = laneSelect(order, off);
        laneMask_c = sel.mask;
        illegal_c  = sel.illegal;
        laneData_c = data << {off, 3'b000};
    end

endmodule

// File: rtl/ldst_dataio_bridge.sv
// Bridges the load/store data port to the word bus: one outstanding transaction,
// posted stores, flush handling including discard of a late read response.
module ldst_dataio_bridge
    import ldst_bridge_pkg::*;
(
    input  logic                iCLOCK,
    input  logic                iRESET_SYNC,
    input  logic                iFREE_EX,
    input  logic                iDATAIO_REQ,
    output logic                oDATAIO_BUSY,
    input  logic [ORDER_W-1:0]  iDATAIO_ORDER,
    input  logic                iDATAIO_RW,
    input  logic [TID_W-1:0]    iDATAIO_TID,
    input  logic [MMUMOD_W-1:0] iDATAIO_MMUMOD,
    input  logic [ADDR_W-1:0]   iDATAIO_PDT,
    input  logic [ADDR_W-1:0]   iDATAIO_ADDR,
    input  logic [DATA_W-1:0]   iDATAIO_DATA,
    output logic                oDATAIO_VALID,
    output logic [DATA_W-1:0]   oDATAIO_DATA,
    output logic                oDATAIO_MISALIGN,
    output logic                oMEM_REQ,
    input  logic                iMEM_LOCK,
    output logic                oMEM_RW,
    output logic [ADDR_W-1:0]   oMEM_ADDR,
    output logic [MASK_W-1:0]   oMEM_MASK,
    output logic [DATA_W-1:0]   oMEM_DATA,
    output logic [TID_W-1:0]    oMEM_TID,
    output logic [MMUMOD_W-1:0] oMEM_MMUMOD,
    output logic [ADDR_W-1:0]   oMEM_PDT,
    input  logic                iMEM_VALID,
    input  logic [DATA_W-1:0]   iMEM_DATA
);

    bridgeState_t        state;
    logic                busy;
    logic                memReq;
    memPayload_t         payload;
    logic                dataioValid;
    logic                dataioMisalign;
    logic [DATA_W-1:0]   dataioData;

    logic [MASK_W-1:0]   laneMask;
    logic [DATA_W-1:0]   laneData;
    logic                laneIllegal;
    logic                accept;
    logic                transfer;

    dataio_lane_encoder uLaneEncoder (
        .order      (order_t'(iDATAIO_ORDER)),
        .off        (iDATAIO_ADDR[OFF_W-1:0]),
        .data       (iDATAIO_DATA),
        .laneMask_c (laneMask),
        .laneData_c (laneData),
        .illegal_c  (laneIllegal)
    );

    assign accept   = iDATAIO_REQ && !iFREE_EX && (state == STATE_IDLE);
    assign transfer = memReq && !iMEM_LOCK;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state          <= STATE_IDLE;
            busy           <= 1'b0;
            memReq         <= 1'b0;
            payload        <= '0;
            dataioValid    <= 1'b0;
            dataioMisalign <= 1'b0;
            dataioData     <= '0;
        end else begin
            dataioValid    <= 1'b0;
            dataioMisalign <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (accept) begin
                        if (laneIllegal) begin
                            // Rejected access never reaches the bus; reads still get a zero return.
                            dataioMisalign <= 1'b1;
                            if (!iDATAIO_RW) begin
                                dataioValid <= 1'b1;
                                dataioData  <= '0;
                            end
                        end else begin
                            state          <= STATE_ISSUE;
                            busy           <= 1'b1;
                            memReq         <= 1'b1;
                            payload.rw     <= iDATAIO_RW;
                            payload.tid    <= iDATAIO_TID;
                            payload.mmuMod <= iDATAIO_MMUMOD;
                            payload.pdt    <= iDATAIO_PDT;
                            payload.addr   <= {iDATAIO_ADDR[ADDR_W-1:OFF_W], 2'b00};
                            payload.mask   <= laneMask;
                            payload.data   <= laneData;
                        end
                    end
                end
                STATE_ISSUE: begin
                    if (transfer) begin
                        memReq <= 1'b0;
                        if (payload.rw) begin
                            state <= STATE_IDLE;
                            busy  <= 1'b0;
                        end else if (iFREE_EX) begin
                            // The read already left on the bus, so its response must be swallowed.
                            state <= STATE_DRAIN;
                        end else begin
                            state <= STATE_WAIT_RD;
                        end
                    end else if (iFREE_EX && !payload.rw) begin
                        state  <= STATE_IDLE;
                        busy   <= 1'b0;
                        memReq <= 1'b0;
                    end
                end
                STATE_WAIT_RD: begin
                    if (iMEM_VALID) begin
                        state <= STATE_IDLE;
                        busy  <= 1'b0;
                        if (!iFREE_EX) begin
                            dataioValid <= 1'b1;
                            dataioData  <= iMEM_DATA;
                        end
                    end else if (iFREE_EX) begin
                        state <= STATE_DRAIN;
                    end
                end
                STATE_DRAIN: begin
                    if (iMEM_VALID) begin
                        state <= STATE_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= STATE_IDLE;
                    busy   <= 1'b0;
                    memReq <= 1'b0;
                end
            endcase
        end
    end

    assign oDATAIO_BUSY     = busy;
    assign oDATAIO_VALID    = dataioValid;
    assign oDATAIO_DATA     = dataioData;
    assign oDATAIO_MISALIGN = dataioMisalign;
    assign oMEM_REQ         = memReq;
    assign oMEM_RW          = payload.rw;
    assign oMEM_ADDR        = payload.addr;
    assign oMEM_MASK        = payload.mask;
    assign oMEM_DATA        = payload.data;
    assign oMEM_TID         = payload.tid;
    assign oMEM_MMUMOD      = payload.mmuMod;
    assign oMEM_PDT         = payload.pdt;

endmodule

// File: tb/tb_ldst_dataio_bridge.sv
// Randomised transaction-level bench for ldst_dataio_bridge with directed flush/reset cases.
module tb_ldst_dataio_bridge;

    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC = 1'b1;
    logic        iFREE_EX = 1'b0;
    logic        iDATAIO_REQ = 1'b0;
    logic [1:0]  iDATAIO_ORDER = 2'd0;
    logic        iDATAIO_RW = 1'b0;
    logic [13:0] iDATAIO_TID = '0;
    logic [1:0]  iDATAIO_MMUMOD = '0;
    logic [31:0] iDATAIO_PDT = '0;
    logic [31:0] iDATAIO_ADDR = '0;
    logic [31:0] iDATAIO_DATA = '0;
    logic        iMEM_LOCK = 1'b0;
    logic        iMEM_VALID = 1'b0;
    logic [31:0] iMEM_DATA = '0;

    logic        oDATAIO_BUSY;
    logic        oDATAIO_VALID;
    logic [31:0] oDATAIO_DATA;
    logic        oDATAIO_MISALIGN;
    logic        oMEM_REQ;
    logic        oMEM_RW;
    logic [31:0] oMEM_ADDR;
    logic [3:0]  oMEM_MASK;
    logic [31:0] oMEM_DATA;
    logic [13:0] oMEM_TID;
    logic [1:0]  oMEM_MMUMOD;
    logic [31:0] oMEM_PDT;

    int checkCount = 0;
    int passCount  = 0;

    ldst_dataio_bridge dut (
        .iCLOCK           (iCLOCK),
        .iRESET_SYNC      (iRESET_SYNC),
        .iFREE_EX         (iFREE_EX),
        .iDATAIO_REQ      (iDATAIO_REQ),
        .oDATAIO_BUSY     (oDATAIO_BUSY),
        .iDATAIO_ORDER    (iDATAIO_ORDER),
        .iDATAIO_RW       (iDATAIO_RW),
        .iDATAIO_TID      (iDATAIO_TID),
        .iDATAIO_MMUMOD   (iDATAIO_MMUMOD),
        .iDATAIO_PDT      (iDATAIO_PDT),
        .iDATAIO_ADDR     (iDATAIO_ADDR),
        .iDATAIO_DATA     (iDATAIO_DATA),
        .oDATAIO_VALID    (oDATAIO_VALID),
        .oDATAIO_DATA     (oDATAIO_DATA),
        .oDATAIO_MISALIGN (oDATAIO_MISALIGN),
        .oMEM_REQ         (oMEM_REQ),
        .iMEM_LOCK        (iMEM_LOCK),
        .oMEM_RW          (oMEM_RW),
        .oMEM_ADDR        (oMEM_ADDR),
        .oMEM_MASK        (oMEM_MASK),
        .oMEM_DATA        (oMEM_DATA),
        .oMEM_TID         (oMEM_TID),
        .oMEM_MMUMOD      (oMEM_MMUMOD),
        .oMEM_PDT         (oMEM_PDT),
        .iMEM_VALID       (iMEM_VALID),
        .iMEM_DATA        (iMEM_DATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else
            passCount++;
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, ".busy"},     32'(oDATAIO_BUSY), 32'd0);
        checkVal({tag, ".valid"},    32'(oDATAIO_VALID), 32'd0);
        checkVal({tag, ".rdata"},    oDATAIO_DATA, 32'd0);
        checkVal({tag, ".misalign"}, 32'(oDATAIO_MISALIGN), 32'd0);
        checkVal({tag, ".req"},      32'(oMEM_REQ), 32'd0);
        checkVal({tag, ".rw"},       32'(oMEM_RW), 32'd0);
        checkVal({tag, ".addr"},     oMEM_ADDR, 32'd0);
        checkVal({tag, ".mask"},     32'(oMEM_MASK), 32'd0);
        checkVal({tag, ".wdata"},    oMEM_DATA, 32'd0);
        checkVal({tag, ".tid"},      32'(oMEM_TID), 32'd0);
        checkVal({tag, ".mmu"},      32'(oMEM_MMUMOD), 32'd0);
        checkVal({tag, ".pdt"},      oMEM_PDT, 32'd0);
    endtask

    task automatic driveReq(input logic [1:0] order, input logic rw, input logic [31:0] addr,
                            input logic [31:0] data, output logic [13:0] tid,
                            output logic [1:0] mmu, output logic [31:0] pdt);
        tid = 14'($urandom);
        mmu = 2'($urandom);
        pdt = $urandom;
        iDATAIO_REQ    = 1'b1;
        iDATAIO_ORDER  = order;
        iDATAIO_RW     = rw;
        iDATAIO_ADDR   = addr;
        iDATAIO_DATA   = data;
        iDATAIO_TID    = tid;
        iDATAIO_MMUMOD = mmu;
        iDATAIO_PDT    = pdt;
    endtask

    // Reference: access of (1<<order) bytes at offset off is legal iff it fits in the word.
    task automatic doTxn(input string tag, input logic [1:0] order, input logic rw,
                         input logic [31:0] addr, input logic [31:0] data,
                         input int lockCycles, input int respDelay, input logic [31:0] rdata);
        int size, off;
        logic legal;
        logic [3:0] expMask;
        logic [63:0] wide;
        logic [31:0] expData;
        logic [13:0] tid;
        logic [1:0] mmu;
        logic [31:0] pdt;
        off   = int'(addr % 4);
        size  = (order == 2'd3) ? 0 : (1 << order);
        legal = (order != 2'd3) && (off + size <= 4);
        expMask = legal ? 4'(((1 << size) - 1) << off) : 4'd0;
        wide    = 64'(data) << (8 * off);
        expData = wide[31:0];

        driveReq(order, rw, addr, data, tid, mmu, pdt);
        tick();
        iDATAIO_REQ = 1'b0;
        iMEM_VALID  = 1'b0;

        if (!legal) begin
            checkVal({tag, ".bad.busy"},     32'(oDATAIO_BUSY), 32'd0);
            checkVal({tag, ".bad.req"},      32'(oMEM_REQ), 32'd0);
            checkVal({tag, ".bad.misalign"}, 32'(oDATAIO_MISALIGN), 32'd1);
            checkVal({tag, ".bad.valid"},    32'(oDATAIO_VALID), 32'(!rw));
            if (!rw) checkVal({tag, ".bad.rdata"}, oDATAIO_DATA, 32'd0);
            tick();
            checkVal({tag, ".bad.misalign1"}, 32'(oDATAIO_MISALIGN), 32'd0);
            checkVal({tag, ".bad.valid1"},    32'(oDATAIO_VALID), 32'd0);
            checkVal({tag, ".bad.req1"},      32'(oMEM_REQ), 32'd0);
            return;
        end

        checkVal({tag, ".busy"},     32'(oDATAIO_BUSY), 32'd1);
        checkVal({tag, ".req"},      32'(oMEM_REQ), 32'd1);
        checkVal({tag, ".rw"},       32'(oMEM_RW), 32'(rw));
        checkVal({tag, ".addr"},     oMEM_ADDR, addr & 32'hFFFF_FFFC);
        checkVal({tag, ".mask"},     32'(oMEM_MASK), 32'(expMask));
        checkVal({tag, ".tid"},      32'(oMEM_TID), 32'(tid));
        checkVal({tag, ".mmu"},      32'(oMEM_MMUMOD), 32'(mmu));
        checkVal({tag, ".pdt"},      oMEM_PDT, pdt);
        checkVal({tag, ".valid0"},   32'(oDATAIO_VALID), 32'd0);
        checkVal({tag, ".misalign"}, 32'(oDATAIO_MISALIGN), 32'd0);
        if (rw) checkVal({tag, ".wdata"}, oMEM_DATA, expData);

        for (int k = 0; k < lockCycles; k++) begin
            iMEM_LOCK = 1'b1;
            tick();
            checkVal({tag, ".lock.req"},  32'(oMEM_REQ), 32'd1);
            checkVal({tag, ".lock.addr"}, oMEM_ADDR, addr & 32'hFFFF_FFFC);
            checkVal({tag, ".lock.mask"}, 32'(oMEM_MASK), 32'(expMask));
            if (rw) checkVal({tag, ".lock.wdata"}, oMEM_DATA, expData);
        end
        iMEM_LOCK = 1'b0;
        tick();
        checkVal({tag, ".xfer.req"}, 32'(oMEM_REQ), 32'd0);
        if (rw) begin
            checkVal({tag, ".xfer.busy"}, 32'(oDATAIO_BUSY), 32'd0);
            return;
        end
        checkVal({tag, ".xfer.busy"}, 32'(oDATAIO_BUSY), 32'd1);
        for (int k = 0; k < respDelay; k++) begin
            tick();
            checkVal({tag, ".wait.busy"},  32'(oDATAIO_BUSY), 32'd1);
            checkVal({tag, ".wait.valid"}, 32'(oDATAIO_VALID), 32'd0);
        end
        iMEM_VALID = 1'b1;
        iMEM_DATA  = rdata;
        tick();
        iMEM_VALID = 1'b0;
        checkVal({tag, ".ret.valid"}, 32'(oDATAIO_VALID), 32'd1);
        checkVal({tag, ".ret.data"},  oDATAIO_DATA, rdata);
        checkVal({tag, ".ret.busy"},  32'(oDATAIO_BUSY), 32'd0);
    endtask

    // Issues a legal word read and leaves the bridge waiting for the response.
    task automatic startRead(input logic [31:0] addr);
        logic [13:0] tid;
        logic [1:0] mmu;
        logic [31:0] pdt;
        driveReq(2'd2, 1'b0, addr, 32'd0, tid, mmu, pdt);
        tick();
        iDATAIO_REQ = 1'b0;
        tick();
    endtask

    initial begin
        logic [13:0] tid;
        logic [1:0] mmu;
        logic [31:0] pdt;

        tick();
        tick();
        checkAllZero("reset");
        iRESET_SYNC = 1'b0;

        doTxn("bytewr",  2'd0, 1'b1, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'd0);
        checkVal("bytewr.mask", 32'(oMEM_MASK), 32'h8);
        checkVal("bytewr.data", oMEM_DATA, 32'hAB00_0000);
        doTxn("wordrd",  2'd2, 1'b0, 32'h0000_2000, 32'd0, 3, 1, 32'hDEAD_BEEF);
        doTxn("halfbad", 2'd1, 1'b0, 32'h0000_3003, 32'd0, 0, 0, 32'd0);

        // Flush while waiting for read data: response is discarded.
        startRead(32'h0000_4000);
        iFREE_EX = 1'b1;
        tick();
        iFREE_EX = 1'b0;
        checkVal("drain.busy0", 32'(oDATAIO_BUSY), 32'd1);
        tick();
        tick();
        checkVal("drain.busy2", 32'(oDATAIO_BUSY), 32'd1);
        iMEM_VALID = 1'b1;
        iMEM_DATA  = 32'h1234_5678;
        tick();
        iMEM_VALID = 1'b0;
        checkVal("drain.valid", 32'(oDATAIO_VALID), 32'd0);
        checkVal("drain.busy",  32'(oDATAIO_BUSY), 32'd0);

        // Flush during a stalled store: the store still goes out.
        driveReq(2'd1, 1'b1, 32'h0000_5002, 32'h0000_CAFE, tid, mmu, pdt);
        tick();
        iDATAIO_REQ = 1'b0;
        iMEM_LOCK   = 1'b1;
        tick();
        iFREE_EX = 1'b1;
        tick();
        iFREE_EX = 1'b0;
        checkVal("wrflush.req",  32'(oMEM_REQ), 32'd1);
        checkVal("wrflush.mask", 32'(oMEM_MASK), 32'hC);
        checkVal("wrflush.data", oMEM_DATA, 32'hCAFE_0000);
        iMEM_LOCK = 1'b0;
        tick();
        checkVal("wrflush.done", 32'(oMEM_REQ), 32'd0);
        checkVal("wrflush.busy", 32'(oDATAIO_BUSY), 32'd0);

        // Flush a stalled read before it transfers: request is dropped.
        driveReq(2'd0, 1'b0, 32'h0000_6001, 32'd0, tid, mmu, pdt);
        tick();
        iDATAIO_REQ = 1'b0;
        iMEM_LOCK   = 1'b1;
        iFREE_EX    = 1'b1;
        tick();
        iFREE_EX  = 1'b0;
        iMEM_LOCK = 1'b0;
        checkVal("rdcancel.req",  32'(oMEM_REQ), 32'd0);
        checkVal("rdcancel.busy", 32'(oDATAIO_BUSY), 32'd0);

        // Flush in IDLE suppresses a same-cycle request.
        driveReq(2'd2, 1'b1, 32'h0000_7000, 32'h1, tid, mmu, pdt);
        iFREE_EX = 1'b1;
        tick();
        iFREE_EX    = 1'b0;
        iDATAIO_REQ = 1'b0;
        checkVal("idleflush.busy", 32'(oDATAIO_BUSY), 32'd0);
        checkVal("idleflush.req",  32'(oMEM_REQ), 32'd0);

        // Response and flush together in WAIT_RD: dropped, back to idle.
        startRead(32'h0000_8000);
        iMEM_VALID = 1'b1;
        iFREE_EX   = 1'b1;
        tick();
        iMEM_VALID = 1'b0;
        iFREE_EX   = 1'b0;
        checkVal("vflush.valid", 32'(oDATAIO_VALID), 32'd0);
        checkVal("vflush.busy",  32'(oDATAIO_BUSY), 32'd0);

        // Reset while waiting for read data.
        startRead(32'h0000_9000);
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        checkAllZero("midreset");
        iMEM_VALID = 1'b1;
        iMEM_DATA  = 32'h5555_AAAA;
        tick();
        iMEM_VALID = 1'b0;
        checkVal("midreset.stray", 32'(oDATAIO_VALID), 32'd0);

        for (int n = 0; n < 60; n++) begin
            iMEM_VALID = ($urandom_range(0, 3) == 0);
            iMEM_DATA  = $urandom;
            doTxn($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), $urandom);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
